// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// spi_master_if : byte handshake and SPI pin bundle for spi_master
// Revision 1.0
// ============================================================================
interface spi_master_if;
  logic [7:0] mosi_byte;
  logic       mosi_tick;
  logic       mosi_ready;
  logic       miso_tick;
  logic [7:0] miso_byte;
  logic       spi_clk;
  logic       spi_miso;
  logic       spi_mosi;

  modport master (
    input  mosi_byte, mosi_tick, spi_miso,
    output mosi_ready, miso_tick, miso_byte, spi_clk, spi_mosi
  );

  modport slave (
    output mosi_byte, mosi_tick, spi_miso,
    input  mosi_ready, miso_tick, miso_byte, spi_clk, spi_mosi
  );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// spi_master : single-byte SPI master, MSB-first, SPI modes 0..3
// Revision 1.0
// ============================================================================
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  wire logic     clk,
  input  wire logic     reset,
  spi_master_if.master  bus
);

  localparam logic c_cpol  = 1'(SPI_MODE >> 1);
  localparam logic c_cpha  = 1'(SPI_MODE);
  localparam int   c_div_w = $clog2(CLKS_PER_HALF_BIT) + 1;
  localparam logic [c_div_w-1:0] c_div_top = c_div_w'(CLKS_PER_HALF_BIT - 1);
  localparam logic [4:0] c_last_sample = c_cpha ? 5'd1 : 5'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_div_w-1:0] r_div;
  logic [4:0]         r_edge;
  logic [7:0]         r_tx;
  logic [7:0]         r_rx;
  logic               r_rx_pend;
  logic               r_ready;
  logic               r_mtick;
  logic [7:0]         r_mbyte;
  logic               r_sclk;
  logic               r_mosi;

  // r_edge counts down from 16, so an even remaining count marks a leading edge
  logic w_toggle;
  logic w_leading;
  logic w_sample;
  logic w_drive;

  assign w_toggle  = (r_state == ST_BUSY) && (r_edge != 5'd0) && (r_div == c_div_top);
  assign w_leading = ~r_edge[0];
  assign w_sample  = w_toggle && (w_leading ^ c_cpha);
  assign w_drive   = c_cpha ? (w_toggle && w_leading)
                            : (w_toggle && !w_leading && (r_edge != 5'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_edge    <= 5'd0;
      r_tx      <= 8'h00;
      r_rx      <= 8'h00;
      r_rx_pend <= 1'b0;
      r_ready   <= 1'b1;
      r_mtick   <= 1'b0;
      r_mbyte   <= 8'h00;
      r_sclk    <= c_cpol;
      r_mosi    <= 1'b0;
    end else begin
      // received byte is published one cycle after its final sample edge
      r_mtick <= 1'b0;
      if (r_rx_pend) begin
        r_mtick   <= 1'b1;
        r_mbyte   <= r_rx;
        r_rx_pend <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.mosi_tick) begin
            r_state <= ST_BUSY;
            r_ready <= 1'b0;
            r_edge  <= 5'd16;
            r_div   <= c_div_w'(1);
            if (!c_cpha) begin
              r_mosi <= bus.mosi_byte[7];
              r_tx   <= {bus.mosi_byte[6:0], 1'b0};
            end else begin
              r_tx   <= bus.mosi_byte;
            end
          end
        end

        ST_BUSY: begin
          if (r_edge == 5'd0) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else if (r_div == c_div_top) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge - 5'd1;
            if (w_sample) begin
              r_rx <= {r_rx[6:0], bus.spi_miso};
              if (r_edge == c_last_sample) begin
                r_rx_pend <= 1'b1;
              end
            end
            if (w_drive) begin
              r_mosi <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mosi_ready = r_ready;
  assign bus.miso_tick  = r_mtick;
  assign bus.miso_byte  = r_mbyte;
  assign bus.spi_clk    = r_sclk;
  assign bus.spi_mosi   = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// tb_spi_master : directed loopback bench, modes 0..3 at N=2 plus mode 0 at N=4
// Revision 1.0
// ============================================================================
module tb_spi_master;

  localparam int c_num = 5;

  logic       clk = 1'b0;
  logic       r_rst   [c_num];
  logic       r_tick  [c_num];
  logic [7:0] r_byte  [c_num];
  logic       w_ready [c_num];
  logic       w_mtick [c_num];
  logic [7:0] w_mbyte [c_num];
  logic       w_sclk  [c_num];
  logic       w_mosi  [c_num];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // instances 0..3 run SPI modes 0..3 at N=2; instance 4 is mode 0 at N=4
  for (genvar g = 0; g < c_num; g++) begin : g_dut
    spi_master_if bus ();
    assign bus.mosi_byte = r_byte[g];
    assign bus.mosi_tick = r_tick[g];
    assign bus.spi_miso  = bus.spi_mosi;
    assign w_ready[g] = bus.mosi_ready;
    assign w_mtick[g] = bus.miso_tick;
    assign w_mbyte[g] = bus.miso_byte;
    assign w_sclk[g]  = bus.spi_clk;
    assign w_mosi[g]  = bus.spi_mosi;

    spi_master #(
      .SPI_MODE          ((g < 4) ? g : 0),
      .CLKS_PER_HALF_BIT ((g < 4) ? 2 : 4)
    ) u_dut (
      .clk   (clk),
      .reset (r_rst[g]),
      .bus   (bus)
    );
  end

  function automatic int mode_of(input int m);
    return (m < 4) ? m : 0;
  endfunction

  function automatic int half_of(input int m);
    return (m < 4) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the instance idle; returns at the negedge where
  // mosi_ready is first seen high again, so a follow-up call is back-to-back.
  task automatic send(input int m, input logic [7:0] tx, input bit busy_poke);
    int n, cpol, cpha, edges, rises, tick_cnt, tick_cyc, last_i, ready_bad, ready_ret;
    bit stable_ok, half_ok, done, leading;
    logic prev_clk, prev_mosi;
    logic [7:0] sent, rxv;
    n = half_of(m);
    cpol = mode_of(m) >> 1;
    cpha = mode_of(m) & 1;
    edges = 0; rises = 0; tick_cnt = 0; tick_cyc = 0; last_i = 0;
    ready_bad = 0; ready_ret = 0; stable_ok = 1; half_ok = 1; done = 0;
    sent = 8'h00; rxv = 8'h00;
    check($sformatf("m%0d_idle_clk_before", m), w_sclk[m], cpol);
    check($sformatf("m%0d_ready_before", m), w_ready[m], 1);
    r_byte[m] = tx;
    r_tick[m] = 1'b1;
    prev_clk  = w_sclk[m];
    prev_mosi = w_mosi[m];
    for (int i = 1; !done && i <= 20 * n + 10; i++) begin
      @(negedge clk);
      if (i == 1) r_tick[m] = 1'b0;
      if (busy_poke && i == 5) begin r_byte[m] = 8'h55; r_tick[m] = 1'b1; end
      if (busy_poke && i == 6) r_tick[m] = 1'b0;
      if (w_sclk[m] !== prev_clk) begin
        edges++;
        if (w_sclk[m] === 1'b1) rises++;
        if (i - last_i != n) half_ok = 0;
        last_i = i;
        leading = (prev_clk === 1'(cpol));
        if (leading == (cpha == 0)) begin
          if (w_mosi[m] !== prev_mosi) stable_ok = 0;
          sent = {sent[6:0], prev_mosi};
        end
      end
      if (w_mtick[m] === 1'b1) begin
        tick_cnt++;
        tick_cyc = i;
        rxv = w_mbyte[m];
      end
      if (i <= 16 * n && w_ready[m] !== 1'b0) ready_bad++;
      if (w_ready[m] === 1'b1) begin
        ready_ret = i;
        done = 1;
      end
      prev_clk  = w_sclk[m];
      prev_mosi = w_mosi[m];
    end
    check($sformatf("m%0d_tx%02h_edges", m, tx), edges, 16);
    check($sformatf("m%0d_tx%02h_rises", m, tx), rises, 8);
    check($sformatf("m%0d_tx%02h_ready_low", m, tx), ready_bad, 0);
    check($sformatf("m%0d_tx%02h_ready_ret", m, tx), ready_ret, 16 * n + 1);
    check($sformatf("m%0d_tx%02h_tick_cnt", m, tx), tick_cnt, 1);
    check($sformatf("m%0d_tx%02h_tick_cyc", m, tx), tick_cyc, cpha ? 16 * n + 1 : 15 * n + 1);
    check($sformatf("m%0d_tx%02h_rx", m, tx), rxv, tx);
    check($sformatf("m%0d_tx%02h_sent", m, tx), sent, tx);
    check($sformatf("m%0d_tx%02h_mosi_stable", m, tx), stable_ok, 1);
    check($sformatf("m%0d_tx%02h_half_period", m, tx), half_ok, 1);
    check($sformatf("m%0d_tx%02h_idle_clk_after", m, tx), w_sclk[m], cpol);
  endtask

  initial begin
    int bad;
    for (int m = 0; m < c_num; m++) begin
      r_rst[m]  = 1'b1;
      r_tick[m] = 1'b0;
      r_byte[m] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < c_num; m++) r_rst[m] = 1'b0;

    for (int m = 0; m < c_num; m++) begin
      check($sformatf("m%0d_rst_ready", m), w_ready[m], 1);
      check($sformatf("m%0d_rst_tick", m), w_mtick[m], 0);
      check($sformatf("m%0d_rst_byte", m), w_mbyte[m], 8'h00);
      check($sformatf("m%0d_rst_clk", m), w_sclk[m], mode_of(m) >> 1);
      check($sformatf("m%0d_rst_mosi", m), w_mosi[m], 0);
    end

    for (int m = 0; m < 4; m++) begin
      send(m, 8'hC1, 1'b0);
      send(m, 8'hBE, 1'b0);
      send(m, 8'hEF, 1'b0);
    end

    // strobe while busy must be dropped, not queued
    send(0, 8'hA3, 1'b1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (w_ready[0] !== 1'b1 || w_sclk[0] !== 1'b0 || w_mtick[0] !== 1'b0) bad++;
    end
    check("m0_busy_no_requeue", bad, 0);

    // mid-transfer reset on the N=4 instance, with a strobe in the reset cycle
    r_byte[4] = 8'hA5;
    r_tick[4] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) r_tick[4] = 1'b0;
    end
    check("m4_busy_before_reset", w_ready[4], 0);
    r_rst[4]  = 1'b1;
    r_tick[4] = 1'b1;
    r_byte[4] = 8'hFF;
    @(negedge clk);
    r_rst[4]  = 1'b0;
    r_tick[4] = 1'b0;
    check("m4_abort_clk", w_sclk[4], 0);
    check("m4_abort_ready", w_ready[4], 1);
    check("m4_abort_tick", w_mtick[4], 0);
    check("m4_abort_byte", w_mbyte[4], 8'h00);
    check("m4_abort_mosi", w_mosi[4], 0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (w_mtick[4] !== 1'b0 || w_ready[4] !== 1'b1) bad++;
    end
    check("m4_abort_quiet", bad, 0);
    send(4, 8'h3C, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Single-byte SPI master serialiser. It takes a byte from the on-chip side on a one-cycle strobe and shifts it out MSB-first on spi_mosi. At the same time it shifts in one byte from spi_miso and returns it with a one-cycle valid pulse. It sits between a host/controller FSM and an external SPI slave, and provides spi_clk only (chip-select is the user's responsibility). The RTL module is named spi_master.

## Interface
- SPI_MODE, default 0: 0..3. CPOL = SPI_MODE[1] (mode 2,3 → idle-high clock). CPHA = SPI_MODE[0] (mode 1,3).
- CLKS_PER_HALF_BIT, default 2: clk cycles per spi_clk half period. Must be ≥2.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- mosi_byte  in  8  byte to transmit; sampled when accepted.
- mosi_tick  in  1  one-cycle strobe requesting transmission of mosi_byte.
- mosi_ready  out  1  high = idle, can accept mosi_tick.
- miso_tick  out  1  one-cycle pulse: miso_byte holds a new received byte.
- miso_byte  out  8  last received byte; holds until the next miso_tick.
- spi_clk  out  1  SPI serial clock; idles at CPOL.
- spi_miso  in  1  serial data from slave.
- spi_mosi  out  1  serial data to slave.

## Operation
- States: IDLE (mosi_ready=1) and BUSY (mosi_ready=0).
- IDLE→BUSY: mosi_tick=1 while mosi_ready=1. mosi_byte is latched into the TX shift register and the edge counter is loaded with 16.
- mosi_tick while BUSY is ignored; no queueing.
- Half-bit divider: while BUSY, an spi_clk edge is generated every CLKS_PER_HALF_BIT clk cycles. Edges alternate leading (idle→active) and trailing (active→idle). There are 16 edges per byte and spi_clk returns to CPOL after the 16th edge.
- CPHA=0:
  - Bit 7 is driven on spi_mosi in the cycle after acceptance, before the first edge.
  - spi_miso is sampled on each leading edge.
  - The next bit is driven on each trailing edge except the last.
- CPHA=1:
  - Each bit is driven on a leading edge, bit 7 on edge 1.
  - spi_miso is sampled on each trailing edge.
- RX: bits are shifted in MSB-first, so the first sampled bit becomes miso_byte[7]. After the 8th sample, miso_byte is updated and miso_tick pulses for exactly one cycle.
- BUSY→IDLE: after the 16th edge completes.
- spi_mosi in IDLE holds the last driven bit. After reset it is 0.
- spi_miso is used directly with no synchroniser; the slave must meet setup to the sample edge.

## Timing
Let N = CLKS_PER_HALF_BIT. Cycle 0 is the clk edge at which mosi_tick=1 and mosi_ready=1 are sampled.
- mosi_ready is 0 from cycle 1.
- Edge k (k=1..16) appears on spi_clk at cycle k·N.
- miso_tick is high during the cycle after the final sample edge:
  - CPHA=0: final sample edge is 15, so the pulse is at cycle 15N+1.
  - CPHA=1: final sample edge is 16, so the pulse is at cycle 16N+1.
- mosi_ready returns to 1 at cycle 16N+1.
- A new mosi_tick is accepted in any cycle with mosi_ready=1, including cycle 16N+1. Back-to-back bytes therefore have no gap beyond one cycle.
- Reset values, including reset asserted mid-transfer: mosi_ready=1, miso_tick=0, miso_byte=0x00, spi_clk=CPOL, spi_mosi=0, counters cleared.
  - An aborted byte produces no miso_tick.
  - A mosi_tick asserted in the same cycle as reset is ignored.
- spi_clk high and low times are each exactly N cycles during a byte.

## Test plan
- Mode 0, N=2, spi_miso looped to spi_mosi, send 0xC1:
  - exactly 16 spi_clk edges, 8 rising;
  - mosi_ready low for cycles 1..32;
  - miso_tick once, with miso_byte=0xC1.
- Same loopback, send 0xBE then 0xEF, each issued at the first cycle mosi_ready=1 → received 0xBE then 0xEF, one miso_tick each.
- Repeat 0xC1/0xBE/0xEF loopback for SPI_MODE 1, 2 and 3 → received equals sent in each mode.
- Check per mode:
  - spi_clk idle level equals CPOL before and after the byte;
  - spi_mosi is stable at every sample edge;
  - miso_tick lands at cycle 15N+1 (CPHA=0) or 16N+1 (CPHA=1).
- Busy strobe: pulse mosi_tick with 0x55 at cycle 5 of a 0xA3 transfer → only 0xA3 is shifted out and 0x55 is never transmitted.
- Reset at cycle 10 of a transfer (N=4):
  - next cycle: spi_clk=CPOL, mosi_ready=1, no miso_tick;
  - a following 0x3C transfer then loops back 0x3C.
